// File: rtl/j_scan_controller.sv
// JPEG block-order scan sequencer: walks a frame tile by tile and emits one
// (row, col) coordinate per accepted valid/ready beat.
module j_scan_controller #(
   parameter int CNT_BITS = 13,
   parameter int BLK_SIZE = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [CNT_BITS-1:0] img_width,
   input  logic [CNT_BITS-1:0] img_height,
   input  logic                addr_ready,
   output logic                addr_valid,
   output logic [CNT_BITS-1:0] row,
   output logic [CNT_BITS-1:0] col,
   output logic                blk_last,
   output logic                frame_last,
   output logic                busy,
   output logic                done,
   output logic                dim_err
);

   localparam int LB = $clog2(BLK_SIZE);
   localparam int BW = CNT_BITS - LB;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_q;
   logic [LB-1:0]   in_col_q, in_row_q, in_col_d, in_row_d;
   logic [BW-1:0]   blk_col_q, blk_row_q, blk_col_d, blk_row_d;
   logic [BW-1:0]   wmax_q, hmax_q;
   logic            dim_err_q;
   logic            in_col_end, in_row_end, blk_col_end, blk_row_end;
   logic            tile_end, legal;

   // BLK_SIZE is a power of two, so an all-ones in-tile counter is its max
   assign in_col_end  = &in_col_q;
   assign in_row_end  = &in_row_q;
   assign blk_col_end = (blk_col_q == wmax_q);
   assign blk_row_end = (blk_row_q == hmax_q);
   assign tile_end    = in_col_end && in_row_end;

   assign legal = (|img_width[CNT_BITS-1:LB])  && (img_width[LB-1:0] == '0) &&
                  (|img_height[CNT_BITS-1:LB]) && (img_height[LB-1:0] == '0);

   always_comb begin
      in_col_d  = in_col_q + 1'b1;
      in_row_d  = in_col_end ? in_row_q + 1'b1 : in_row_q;
      blk_col_d = blk_col_q;
      blk_row_d = blk_row_q;
      if (tile_end) begin
         blk_col_d = blk_col_end ? '0 : blk_col_q + 1'b1;
         if (blk_col_end)
            blk_row_d = blk_row_end ? '0 : blk_row_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         in_col_q  <= '0;
         in_row_q  <= '0;
         blk_col_q <= '0;
         blk_row_q <= '0;
         wmax_q    <= '0;
         hmax_q    <= '0;
         dim_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (legal) begin
                     state_q   <= SCAN;
                     dim_err_q <= 1'b0;
                     wmax_q    <= img_width[CNT_BITS-1:LB] - 1'b1;
                     hmax_q    <= img_height[CNT_BITS-1:LB] - 1'b1;
                  end else begin
                     dim_err_q <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (abort) begin
                  state_q   <= IDLE;
                  in_col_q  <= '0;
                  in_row_q  <= '0;
                  blk_col_q <= '0;
                  blk_row_q <= '0;
               end else if (addr_ready) begin
                  in_col_q  <= in_col_d;
                  in_row_q  <= in_row_d;
                  blk_col_q <= blk_col_d;
                  blk_row_q <= blk_row_d;
                  if (tile_end && blk_col_end && blk_row_end)
                     state_q <= DONE;
               end
            end
            default: begin
               state_q   <= IDLE;
               in_col_q  <= '0;
               in_row_q  <= '0;
               blk_col_q <= '0;
               blk_row_q <= '0;
            end
         endcase
      end
   end

   assign addr_valid = (state_q == SCAN);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign dim_err    = dim_err_q;
   assign row        = {blk_row_q, in_row_q};
   assign col        = {blk_col_q, in_col_q};
   assign blk_last   = addr_valid && tile_end;
   assign frame_last = blk_last && blk_col_end && blk_row_end;

endmodule

// File: tb/tb_j_scan_controller.sv
// Scoreboard bench for j_scan_controller: expected beats come from a nested
// tile-order walk of the frame; a negedge monitor pops and compares.
module tb_j_scan_controller;

   localparam int CB = 13;
   localparam int B  = 8;

   logic          clk = 1'b0;
   logic          rst, start, abort, addr_ready;
   logic [CB-1:0] img_width, img_height;
   logic          addr_valid, blk_last, frame_last, busy, done, dim_err;
   logic [CB-1:0] row, col;

   typedef struct {int r; int c; bit bl; bit fl;} beat_t;

   beat_t q[$];
   int    cmp_cnt = 0, err_cnt = 0, pops = 0, done_cnt = 0, cyc = 0, rmode = 0;
   bit    flush = 1'b0, pend_done = 1'b0;

   j_scan_controller #(.CNT_BITS(CB), .BLK_SIZE(B)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .img_width(img_width), .img_height(img_height), .addr_ready(addr_ready),
      .addr_valid(addr_valid), .row(row), .col(col), .blk_last(blk_last),
      .frame_last(frame_last), .busy(busy), .done(done), .dim_err(dim_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: tiles left-to-right, top-to-bottom, raster order inside a tile
   task automatic push_frame(input int w, input int h);
      beat_t e;
      for (int br = 0; br < h / B; br++)
         for (int bc = 0; bc < w / B; bc++)
            for (int ir = 0; ir < B; ir++)
               for (int ic = 0; ic < B; ic++) begin
                  e.r  = br * B + ir;
                  e.c  = bc * B + ic;
                  e.bl = (ir == B - 1) && (ic == B - 1);
                  e.fl = e.bl && (br == h / B - 1) && (bc == w / B - 1);
                  q.push_back(e);
               end
   endtask

   // Ready driver: 0 = always, 1 = 1-0-0-1 pattern, 2 = random
   initial begin
      addr_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         cyc++;
         case (rmode)
            0:       addr_ready = 1'b1;
            1:       addr_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: addr_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: every valid cycle must present the head of the queue (this also
   // proves stability across stalls); pop on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (rst || flush) begin
            pend_done = 1'b0;
         end else begin
            if (pend_done) begin
               chk("done_pulse", done, 1);
               chk("done_no_valid", addr_valid, 0);
               chk("done_busy", busy, 1);
               pend_done = 1'b0;
            end else if (done) begin
               chk("spurious_done", done, 0);
            end
            if (addr_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_beat", 1, 0);
               end else begin
                  chk("beat", {row, col, blk_last, frame_last},
                      {13'(q[0].r), 13'(q[0].c), q[0].bl, q[0].fl});
                  if (addr_ready) begin
                     if (q[0].fl) pend_done = 1'b1;
                     void'(q.pop_front());
                     pops++;
                  end
               end
            end
         end
      end
   end

   task automatic start_frame(input int w, input int h);
      bit lg;
      lg = (w > 0) && (h > 0) && (w % B == 0) && (h % B == 0);
      @(posedge clk); #1;
      img_width  = CB'(w);
      img_height = CB'(h);
      start      = 1'b1;
      if (lg) push_frame(w, h);
      @(posedge clk); #1;
      start = 1'b0;
      chk("dim_err", dim_err, {31'd0, !lg});
      chk("valid_after_start", addr_valid, {31'd0, lg});
      chk("busy_after_start", busy, {31'd0, lg});
   endtask

   task automatic wait_done(input int lim);
      int d0, n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < lim) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("done_seen", {31'd0, done_cnt != d0}, 1);
      chk("queue_drained", q.size(), 0);
      chk("idle_after_done", {busy, addr_valid, done}, 0);
      chk("idle_coords", {row, col}, 0);
   endtask

   task automatic wait_pops(input int n, input int lim);
      int p0, k;
      p0 = pops;
      k  = 0;
      while (pops < p0 + n && k < lim) begin
         @(posedge clk);
         k++;
      end
      chk("pops_reached", {31'd0, pops >= p0 + n}, 1);
   endtask

   initial begin
      int w, h;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      img_width = '0; img_height = '0;
      #12;
      chk("reset_outputs", {addr_valid, row, col, blk_last, frame_last, busy, done, dim_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 16x8, ready always high
      rmode = 0;
      start_frame(16, 8);
      wait_done(400);

      // 8x8 with the 1-0-0-1 ready pattern
      rmode = 1;
      start_frame(8, 8);
      wait_done(600);

      // illegal dims, then recovery
      rmode = 0;
      start_frame(12, 8);
      start_frame(0, 8);
      repeat (3) @(posedge clk);
      #1;
      chk("dim_err_sticky", {dim_err, busy}, 2'b10);
      start_frame(8, 8);
      wait_done(400);

      // abort after 20 accepted beats
      rmode = 2;
      start_frame(16, 16);
      wait_pops(20, 2000);
      @(posedge clk); #1;
      flush = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_idle", {addr_valid, busy, done}, 0);
      chk("abort_coords", {row, col}, 0);
      q.delete();
      flush = 1'b0;
      start_frame(8, 8);
      wait_done(1000);

      // asynchronous reset mid-frame
      rmode = 0;
      start_frame(16, 16);
      wait_pops(40, 400);
      #2;
      flush = 1'b1; rst = 1'b1;
      #1;
      chk("async_reset", {addr_valid, row, col, blk_last, frame_last, busy, done, dim_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      flush = 1'b0;

      // start during SCAN must be ignored
      rmode = 2;
      start_frame(16, 8);
      wait_pops(10, 400);
      @(posedge clk); #1;
      img_width = CB'(8); img_height = CB'(8); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1000);

      // randomized frames, some with illegal widths
      for (int i = 0; i < 6; i++) begin
         w = B * $urandom_range(1, 4);
         h = B * $urandom_range(1, 4);
         if ($urandom_range(0, 3) == 0) w = w + $urandom_range(1, B - 1);
         start_frame(w, h);
         if (w % B == 0) wait_done(5000);
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
